// File: rtl/mod_updown_counter.sv
// Parameterised modulo-N up/down counter with prescaled enable, parallel load,
// wrap/saturate boundary handling, terminal count and sticky overflow reporting.
module mod_updown_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf_sticky
);

    localparam int unsigned      PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             boundary;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            psc_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            psc_q   <= psc_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign step = en && (psc_q == PSC_LAST);

    always_comb begin
        count_d  = count_q;
        psc_d    = psc_q;
        wrap_d   = 1'b0;
        boundary = 1'b0;
        // A boundary event or out-of-range load later in this block overrides the clear.
        ovf_d    = ovf_q & ~ovf_clr;

        if (clr) begin
            count_d = '0;
            psc_d   = '0;
        end else if (load) begin
            psc_d = '0;
            if ({1'b0, load_val} < MOD_EXT) begin
                count_d = load_val;
            end else begin
                count_d = MAX_VAL;
                ovf_d   = 1'b1;
            end
        end else if (en) begin
            psc_d = step ? '0 : psc_q + PSC_W'(1);
            if (step) begin
                // Explicit compares keep MODULUS == 2^WIDTH identical to the general case.
                if (up_dn) begin
                    if (count_q == MAX_VAL) begin
                        boundary = 1'b1;
                        count_d  = sat_mode ? count_q : '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        boundary = 1'b1;
                        count_d  = sat_mode ? count_q : MAX_VAL;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end

        if (boundary) begin
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
        end
    end

    assign q          = count_q;
    assign tc         = up_dn ? (count_q == MAX_VAL) : (count_q == '0);
    assign wrap_pulse = wrap_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised self-checking bench: three counter configurations share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_mod_updown_counter;

    localparam int NI = 3;
    localparam int MODS [NI] = '{10, 10, 16};
    localparam int PSCS [NI] = '{1, 3, 1};

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic       sat_mode;
    logic       ovf_clr;

    logic [3:0] q_w    [NI];
    logic       tc_w   [NI];
    logic       wrap_w [NI];
    logic       ovf_w  [NI];

    int m_q    [NI];
    int m_psc  [NI];
    int m_wrap [NI];
    int m_ovf  [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_m10 (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
        .q(q_w[0]), .tc(tc_w[0]), .wrap_pulse(wrap_w[0]), .ovf_sticky(ovf_w[0])
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_m10_p3 (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
        .q(q_w[1]), .tc(tc_w[1]), .wrap_pulse(wrap_w[1]), .ovf_sticky(ovf_w[1])
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_m16 (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
        .q(q_w[2]), .tc(tc_w[2]), .wrap_pulse(wrap_w[2]), .ovf_sticky(ovf_w[2])
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_q[i] = 0; m_psc[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
        end
    endtask

    // Next state of one counter from the behavioural rules, using plain integer arithmetic.
    task automatic model_edge(input int i);
        int m, target, nq, npsc, nwrap, novf;
        m     = MODS[i];
        nq    = m_q[i];
        npsc  = m_psc[i];
        nwrap = 0;
        novf  = (m_ovf[i] != 0 && !ovf_clr) ? 1 : 0;
        if (clr) begin
            nq = 0; npsc = 0;
        end else if (load) begin
            npsc = 0;
            if (int'(load_val) < m) nq = int'(load_val);
            else begin nq = m - 1; novf = 1; end
        end else if (en) begin
            npsc = (m_psc[i] + 1) % PSCS[i];
            if (npsc == 0) begin
                target = up_dn ? m_q[i] + 1 : m_q[i] - 1;
                if (target < 0 || target >= m) begin
                    nwrap = 1;
                    novf  = 1;
                    nq    = sat_mode ? m_q[i] : (target + m) % m;
                end else begin
                    nq = target;
                end
            end
        end
        m_q[i] = nq; m_psc[i] = npsc; m_wrap[i] = nwrap; m_ovf[i] = novf;
    endtask

    task automatic check_all();
        int exp_tc;
        for (int i = 0; i < NI; i++) begin
            exp_tc = up_dn ? ((m_q[i] == MODS[i] - 1) ? 1 : 0) : ((m_q[i] == 0) ? 1 : 0);
            check_eq($sformatf("q[%0d]", i), int'(q_w[i]), m_q[i]);
            check_eq($sformatf("tc[%0d]", i), int'(tc_w[i]), exp_tc);
            check_eq($sformatf("wrap[%0d]", i), int'(wrap_w[i]), m_wrap[i]);
            check_eq($sformatf("ovf[%0d]", i), int'(ovf_w[i]), m_ovf[i]);
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) model_edge(i);
            #1;
            check_all();
        end
    endtask

    // Called at posedge+1; the pulse sits entirely between clock edges.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < NI; i++)
            check_eq($sformatf("rst_q_now[%0d]", i), int'(q_w[i]), 0);
        #1 reset = 1'b0;
    endtask

    task automatic idle();
        clr = 0; en = 0; up_dn = 1; load = 0; load_val = '0; sat_mode = 0; ovf_clr = 0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;

        // Up-count through the modulus in wrap mode.
        en = 1; up_dn = 1;
        cycles(12);

        // Down-count in wrap mode, then saturate at zero.
        clr = 1; cycles(1); clr = 0;
        up_dn = 0;
        cycles(12);
        clr = 1; cycles(1); clr = 0;
        sat_mode = 1;
        cycles(5);
        sat_mode = 0; up_dn = 1;

        // Prescaler with an enable gap.
        clr = 1; cycles(1); clr = 0;
        en = 1; cycles(2);
        en = 0; cycles(1);
        en = 1; cycles(1);
        check_eq("psc3_step", int'(q_w[1]), 1);

        // Loads: in range, out of range, ovf_clr alone, ovf_clr against an event.
        load = 1; load_val = 4'd7; cycles(1);
        load_val = 4'd12; cycles(1);
        load = 0; en = 0; ovf_clr = 1; cycles(1);
        load = 1; load_val = 4'd9; ovf_clr = 0; cycles(1);
        load = 0; en = 1; ovf_clr = 1; cycles(1);
        ovf_clr = 0; cycles(3);

        // Asynchronous reset mid-count, then resume.
        clr = 1; cycles(1); clr = 0;
        en = 1; cycles(5);
        en = 0; cycles(1);
        async_reset();
        en = 1; cycles(4);

        // clr beats load; 15 -> 0 wrap on the full-range instance.
        load = 1; load_val = 4'd15; cycles(1);
        load = 0; cycles(1);
        clr = 1; load = 1; load_val = 4'd5; cycles(1);
        clr = 0; load = 0;

        for (int k = 0; k < 3000; k++) begin
            en       = ($urandom_range(3) != 0);
            up_dn    = ($urandom_range(7) == 0) ? ~up_dn : up_dn;
            sat_mode = ($urandom_range(15) == 0) ? ~sat_mode : sat_mode;
            clr      = ($urandom_range(31) == 0);
            load     = ($urandom_range(15) == 0);
            load_val = 4'($urandom_range(15));
            ovf_clr  = ($urandom_range(7) == 0);
            if ($urandom_range(199) == 0) async_reset();
            cycles(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
